// File: rtl/pipeline_tracker_pkg.sv
// Shared constants and helpers for the pipeline tracker: seven-segment encodings
// and the stage record layout.
package pipeline_tracker_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low gfedcba patterns for hex digits 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam int LEN_DEFAULT = 32;

    typedef struct packed {
        logic [LEN_DEFAULT-1:0] pc;
        logic [LEN_DEFAULT-1:0] instruction;
        logic                   valid;
    } stage_rec_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        return SEG_HEX[value];
    endfunction

endpackage

// File: rtl/pipeline_tracker_pipe_stage_reg.sv
// One pipeline register holding {pc, instruction, valid}; hold freezes it,
// kill loads the incoming data as a bubble.
module pipe_stage_reg
    import pipeline_tracker_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           hold,
    input  logic           kill,
    input  logic [LEN-1:0] next_pc,
    input  logic [LEN-1:0] next_instruction,
    input  logic           next_valid,
    output logic [LEN-1:0] pc,
    output logic [LEN-1:0] instruction,
    output logic           valid
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            instruction <= '0;
            valid       <= 1'b0;
        end else if (!hold) begin
            pc          <= next_pc;
            instruction <= next_instruction;
            valid       <= next_valid & ~kill;
        end
    end

endmodule

// File: rtl/pipeline_tracker.sv
// Parametrised PC/instruction pipeline with stall bubbles, branch flush, a
// retired-instruction counter and a multiplexed per-stage seven-segment display.
module pipeline_tracker
    import pipeline_tracker_pkg::*;
#(
    parameter int LEN         = 32,
    parameter int STAGES      = 4,
    parameter int STALL_STAGE = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int SCAN_DIV    = 50000,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LEN-1:0]    in_pc,
    input  logic [LEN-1:0]    in_instruction,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    output logic              fetch_hold,
    output logic [STAGES-1:0] stage_valid,
    output logic [LEN-1:0]    out_pc,
    output logic [LEN-1:0]    out_instruction,
    output logic              out_valid,
    output logic [CNT_W-1:0]  retired,
    output logic [6:0]        seg,
    output logic [STAGES-1:0] digit_sel
);

    localparam int IDX_W  = $clog2(STAGES);
    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic [LEN-1:0]    pc_q  [STAGES];
    logic [LEN-1:0]    ins_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] hold_v;
    logic [STAGES-1:0] kill_v;

    // Flush wins over stall, so a flushing cycle never freezes fetch or any stage
    assign fetch_hold = stall & ~flush;

    always_comb begin
        hold_v = '0;
        kill_v = '0;
        for (int k = 0; k < STAGES; k++) begin
            hold_v[k] = fetch_hold && (k < STALL_STAGE);
            kill_v[k] = (flush && (k < FLUSH_DEPTH)) || (fetch_hold && (k == STALL_STAGE));
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [LEN-1:0] src_pc;
        logic [LEN-1:0] src_ins;
        logic           src_valid;

        if (k == 0) begin : g_front
            assign src_pc    = in_pc;
            assign src_ins   = in_instruction;
            assign src_valid = in_valid;
        end else begin : g_chain
            assign src_pc    = pc_q[k-1];
            assign src_ins   = ins_q[k-1];
            assign src_valid = valid_q[k-1];
        end

        pipe_stage_reg #(
            .LEN (LEN)
        ) u_stage (
            .clock            (clock),
            .reset            (reset),
            .hold             (hold_v[k]),
            .kill             (kill_v[k]),
            .next_pc          (src_pc),
            .next_instruction (src_ins),
            .next_valid       (src_valid),
            .pc               (pc_q[k]),
            .instruction      (ins_q[k]),
            .valid            (valid_q[k])
        );
    end

    assign stage_valid     = valid_q;
    assign out_pc          = pc_q[STAGES-1];
    assign out_instruction = ins_q[STAGES-1];
    assign out_valid       = valid_q[STAGES-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (out_valid) begin
            retired <= retired + 1'b1;
        end
    end

    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  digit_idx;
    logic [IDX_W-1:0]  next_idx;
    logic              scan_tc;
    logic [STAGES-1:0] sel_next;
    logic [6:0]        seg_next;

    // seg and digit_sel are both derived from next_idx so they land on the same edge
    always_comb begin
        scan_tc  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
        next_idx = digit_idx;
        if (scan_tc) begin
            next_idx = (digit_idx == IDX_W'(STAGES - 1)) ? '0 : digit_idx + 1'b1;
        end
        sel_next           = '0;
        sel_next[next_idx] = 1'b1;
        seg_next           = valid_q[next_idx] ? hex_to_seg(pc_q[next_idx][5:2]) : SEG_DASH;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            digit_sel <= STAGES'(1);
            seg       <= SEG_DASH;
        end else begin
            scan_cnt  <= scan_tc ? '0 : scan_cnt + 1'b1;
            digit_idx <= next_idx;
            digit_sel <= sel_next;
            seg       <= seg_next;
        end
    end

endmodule

// File: tb/tb_pipeline_tracker.sv
// Directed bench for pipeline_tracker with a reference pipeline model feeding
// an expected-output scoreboard.
module tb_pipeline_tracker;

    localparam int LEN = 32;
    localparam int ST  = 4;
    localparam int SS  = 1;
    localparam int FD  = 2;
    localparam int SD  = 4;
    localparam int CW  = 4;

    logic          clock;
    logic          reset;
    logic [LEN-1:0] in_pc;
    logic [LEN-1:0] in_instruction;
    logic          in_valid;
    logic          stall;
    logic          flush;
    logic          fetch_hold;
    logic [ST-1:0] stage_valid;
    logic [LEN-1:0] out_pc;
    logic [LEN-1:0] out_instruction;
    logic          out_valid;
    logic [CW-1:0] retired;
    logic [6:0]    seg;
    logic [ST-1:0] digit_sel;

    pipeline_tracker #(
        .LEN (LEN), .STAGES (ST), .STALL_STAGE (SS), .FLUSH_DEPTH (FD),
        .SCAN_DIV (SD), .CNT_W (CW)
    ) dut (
        .clock (clock), .reset (reset), .in_pc (in_pc), .in_instruction (in_instruction),
        .in_valid (in_valid), .stall (stall), .flush (flush), .fetch_hold (fetch_hold),
        .stage_valid (stage_valid), .out_pc (out_pc), .out_instruction (out_instruction),
        .out_valid (out_valid), .retired (retired), .seg (seg), .digit_sel (digit_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ov;
        logic [3:0]  sv;
        logic [3:0]  ret;
        logic [6:0]  seg;
        logic [3:0]  dsel;
    } exp_t;

    exp_t sb[$];

    logic [6:0]  hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic [31:0] m_pc  [ST];
    logic [31:0] m_ins [ST];
    logic [3:0]  m_v;
    int          m_ret;
    int          m_cnt;
    int          m_idx;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ST; k++) begin
            m_pc[k]  = '0;
            m_ins[k] = '0;
        end
        m_v   = '0;
        m_ret = 0;
        m_cnt = 0;
        m_idx = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".stage_valid"}, 32'(stage_valid), 32'h0);
        chk({tag, ".out_pc"}, out_pc, 32'h0);
        chk({tag, ".out_instruction"}, out_instruction, 32'h0);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, ".retired"}, 32'(retired), 32'h0);
        chk({tag, ".seg"}, 32'(seg), 32'h3F);
        chk({tag, ".digit_sel"}, 32'(digit_sel), 32'h1);
    endtask

    // Advance the reference model by one edge and queue the expected outputs
    task automatic model_edge(input logic [31:0] pc, input logic v, input logic st, input logic fl);
        logic [31:0] n_pc  [ST];
        logic [31:0] n_ins [ST];
        logic [3:0]  n_v;
        logic        fh;
        exp_t        e;
        fh = st & ~fl;
        for (int k = 0; k < ST; k++) begin
            if (fh && k < SS) begin
                n_pc[k] = m_pc[k]; n_ins[k] = m_ins[k]; n_v[k] = m_v[k];
            end else begin
                n_pc[k]  = (k == 0) ? pc : m_pc[k-1];
                n_ins[k] = (k == 0) ? ins_of(pc) : m_ins[k-1];
                n_v[k]   = (k == 0) ? v : m_v[k-1];
                if ((fl && k < FD) || (fh && k == SS)) n_v[k] = 1'b0;
            end
        end
        if (m_v[ST-1]) m_ret = (m_ret + 1) % 16;
        if (m_cnt == SD - 1) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % ST;
        end else begin
            m_cnt = m_cnt + 1;
        end
        e.seg  = m_v[m_idx] ? hex_tab[m_pc[m_idx][5:2]] : 7'h3F;
        e.dsel = 4'(1 << m_idx);
        for (int k = 0; k < ST; k++) begin
            m_pc[k] = n_pc[k]; m_ins[k] = n_ins[k];
        end
        m_v   = n_v;
        e.pc  = m_pc[ST-1];
        e.ins = m_ins[ST-1];
        e.ov  = m_v[ST-1];
        e.sv  = m_v;
        e.ret = 4'(m_ret);
        sb.push_back(e);
    endtask

    task automatic step(input logic [31:0] pc, input logic v, input logic st, input logic fl);
        exp_t e;
        in_pc          = pc;
        in_instruction = ins_of(pc);
        in_valid       = v;
        stall          = st;
        flush          = fl;
        #1;
        chk("fetch_hold", 32'(fetch_hold), 32'(st & ~fl));
        model_edge(pc, v, st, fl);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instruction", out_instruction, e.ins);
        chk("out_valid", 32'(out_valid), 32'(e.ov));
        chk("stage_valid", 32'(stage_valid), 32'(e.sv));
        chk("retired", 32'(retired), 32'(e.ret));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("digit_sel", 32'(digit_sel), 32'(e.dsel));
    endtask

    int sel2_cycles;

    initial begin
        in_pc = '0; in_instruction = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        reset = 1'b1;
        model_reset();
        #2;
        check_reset("reset_async");
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_reset("reset_init");

        // Plain stream: latency STAGES, retirements after the pipe fills
        for (int i = 0; i < 9; i++) begin
            step(32'(i * 4), 1'b1, 1'b0, 1'b0);
            if (i == 3) begin
                chk("latency_out_pc", out_pc, 32'h0);
                chk("latency_out_valid", 32'(out_valid), 32'h1);
            end
        end
        chk("stream_full", 32'(stage_valid), 32'hF);
        chk("stream_retired", 32'(retired), 32'h5);

        // Flush with 0x20,0x1C,0x18,0x14 in flight
        step(32'h24, 1'b1, 1'b0, 1'b1);
        chk("flush_valid", 32'(stage_valid), 32'hC);
        step(32'h28, 1'b1, 1'b0, 1'b0);
        chk("flush_ret_18", out_pc, 32'h1C);
        step(32'h2C, 1'b1, 1'b0, 1'b0);
        step(32'h30, 1'b1, 1'b0, 1'b0);
        chk("flush_retired", 32'(retired), 32'h8);

        // Two-cycle stall with 0x10 held in stage 0
        step(32'h10, 1'b1, 1'b0, 1'b0);
        step(32'h14, 1'b1, 1'b1, 1'b0);
        chk("stall1_bubble", 32'(stage_valid[1]), 32'h0);
        step(32'h14, 1'b1, 1'b1, 1'b0);
        chk("stall2_bubble", 32'(stage_valid[1]), 32'h0);
        step(32'h14, 1'b1, 1'b0, 1'b0);
        chk("stall_release", 32'(stage_valid[1]), 32'h1);
        step(32'h18, 1'b1, 1'b0, 1'b0);
        step(32'h1C, 1'b1, 1'b0, 1'b0);
        chk("stall_late_pc", out_pc, 32'h10);
        chk("stall_late_valid", 32'(out_valid), 32'h1);

        // Stall and flush together: flush wins
        step(32'h20, 1'b1, 1'b1, 1'b1);
        chk("both_front_killed", 32'(stage_valid[1:0]), 32'h0);
        chk("both_back_kept", 32'(stage_valid[3:2]), 32'h3);

        // Scan with every stage holding pc 0x0C
        for (int i = 0; i < 8; i++) step(32'h0C, 1'b1, 1'b0, 1'b0);
        sel2_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            step(32'h0C, 1'b1, 1'b0, 1'b0);
            if (digit_sel == 4'b0100) begin
                sel2_cycles++;
                chk("scan_digit2_seg", 32'(seg), 32'h30);
            end
        end
        chk("scan_digit2_cycles", 32'(sel2_cycles), 32'h4);
        step(32'h0C, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(32'h0C, 1'b0, 1'b0, 1'b0);
        chk("scan_all_dash", 32'(seg), 32'h3F);

        // Reset between edges while valid data is in flight
        for (int i = 0; i < 5; i++) step(32'(i * 4 + 4), 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_reset("reset_mid");
        model_reset();
        #1 reset = 1'b0;

        // Retired counter wrap at CNT_W=4
        for (int i = 0; i < 20; i++) begin
            step(32'(i * 4), 1'b1, 1'b0, 1'b0);
            if (i == 18) chk("wrap_15", 32'(retired), 32'hF);
        end
        chk("wrap_0", 32'(retired), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
